irq_controller: RTL

Eight-line interrupt controller that sits directly upstream of the CPU. It synchronises and edge-detects external sources into a pending register, applies a software mask, and arbitrates by fixed priority with nesting via an in-service register. It presents a single request plus handler vector to the CPU under a request/acknowledge handshake. Its mask and status registers are accessible on the CPU memory bus.

---
 rtl/irq_controller.sv | 120 ++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// Eight-line interrupt controller: synchronised edge capture, mask, fixed priority
// with in-service nesting, and a request/ack handshake to the CPU.
module irq_controller #(
   parameter logic [15:0] VECTOR_BASE = 16'h0010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  irq_lines,
   input  logic        cs,
   input  logic [1:0]  address,
   input  logic        r,
   input  logic        w,
   inout  wire  [15:0] data_bus,
   output logic        irq,
   input  logic        irq_ack,
   output logic [15:0] vector
);
   typedef enum logic [1:0] {IDLE, REQ, ACKED} state_t;

   state_t      r_state;
   logic [7:0]  r_s1, r_s2, r_s3;
   logic [1:0]  r_arm;
   logic [7:0]  r_mask, r_pend, r_isr;
   logic [2:0]  r_idx;
   logic        r_irq;
   logic [15:0] r_vector;

   logic [7:0]  w_rise, w_elig, w_cand_oh, w_isr_low;
   logic [7:0]  w_w1c, w_eoi_clr, w_ack_set;
   logic [2:0]  w_cand_idx;
   logic        w_req_ok, w_ack, w_wr_mask, w_wr_pend, w_wr_eoi;
   logic [15:0] w_rdata;

   assign w_rise    = r_s2 & ~r_s3;
   assign w_elig    = r_pend & r_mask;
   assign w_cand_oh = w_elig & (~w_elig + 8'd1);
   assign w_isr_low = r_isr & (~r_isr + 8'd1);
   // One-hot compare: a lower index is a numerically smaller one-hot value.
   assign w_req_ok  = (w_elig != 8'd0) && ((r_isr == 8'd0) || (w_cand_oh < w_isr_low));

   always_comb begin
      w_cand_idx = 3'd0;
      for (int n = 7; n >= 0; n--)
         if (w_elig[n]) w_cand_idx = 3'(n);
   end

   assign w_ack     = (r_state == REQ) && irq_ack;
   assign w_wr_mask = cs && w && (address == 2'd0);
   assign w_wr_pend = cs && w && (address == 2'd1);
   assign w_wr_eoi  = cs && w && (address == 2'd3);
   assign w_w1c     = w_wr_pend ? data_bus[7:0] : 8'd0;
   assign w_eoi_clr = w_wr_eoi ? w_isr_low : 8'd0;
   assign w_ack_set = w_ack ? (8'd1 << r_idx) : 8'd0;

   always_comb begin
      w_rdata = 16'd0;
      case (address)
         2'd0:    w_rdata = {8'd0, r_mask};
         2'd1:    w_rdata = {8'd0, r_pend};
         2'd2:    w_rdata = {8'd0, r_isr};
         default: w_rdata = 16'd0;
      endcase
   end

   assign data_bus = (cs && r) ? w_rdata : 16'hzzzz;
   assign irq      = r_irq;
   assign vector   = r_vector;

   // s3 stays all-ones until the synchroniser has refilled after reset, so a
   // line already high at release is seen as a level, not an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1  <= 8'h00;
         r_s2  <= 8'h00;
         r_s3  <= 8'hFF;
         r_arm <= 2'b00;
      end else begin
         r_s1  <= irq_lines;
         r_s2  <= r_s1;
         r_s3  <= r_arm[1] ? r_s2 : 8'hFF;
         r_arm <= {r_arm[0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mask <= 8'h00;
         r_pend <= 8'h00;
         r_isr  <= 8'h00;
      end else begin
         if (w_wr_mask) r_mask <= data_bus[7:0];
         r_pend <= (r_pend & ~w_w1c & ~w_ack_set) | w_rise;
         r_isr  <= (r_isr & ~w_eoi_clr) | w_ack_set;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_irq    <= 1'b0;
         r_idx    <= 3'd0;
         r_vector <= VECTOR_BASE;
      end else begin
         case (r_state)
            IDLE: if (w_req_ok) begin
               r_state  <= REQ;
               r_irq    <= 1'b1;
               r_idx    <= w_cand_idx;
               r_vector <= VECTOR_BASE + {13'd0, w_cand_idx};
            end
            REQ: if (irq_ack) begin
               r_state <= ACKED;
               r_irq   <= 1'b0;
            end
            ACKED:   r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
